// File: rtl/conv_frame_sequencer_if.sv
// Upstream valid/ready pixel-beat stream feeding the frame sequencer.
interface conv_frame_sequencer_if #(
    parameter int PORT_BITS = 128
);
    logic                 s_valid;
    logic                 s_ready;
    logic [PORT_BITS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller for convolution_core: streams one ROI frame, then injects zero
// flush beats until every output beat is seen, with a watchdog on the flush phase.
module conv_frame_sequencer #(
    parameter int ROI_SIZE  = 480,
    parameter int PORT_BITS = 128,
    parameter int IN_WIDTH  = 8,
    parameter int FLUSH_MAX = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    conv_frame_sequencer_if.slave s_if,
    output logic                  core_clk_en,
    output logic                  core_conv_en,
    output logic [PORT_BITS-1:0]  core_din,
    input  logic                  core_vld,
    output logic                  m_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           frame_cnt
);
    localparam int NUM_PER_CYCLE = PORT_BITS / IN_WIDTH;
    localparam int BEATS         = ROI_SIZE * ROI_SIZE / NUM_PER_CYCLE;
    localparam int IN_CW         = $clog2(BEATS + 1);
    localparam int FL_CW         = $clog2(FLUSH_MAX + 1);

    localparam logic [IN_CW-1:0] C_BEATS   = IN_CW'(BEATS);
    localparam logic [IN_CW-1:0] C_LAST_IN = IN_CW'(BEATS - 1);
    localparam logic [FL_CW-1:0] C_FL_LAST = FL_CW'(FLUSH_MAX - 1);

    if ((ROI_SIZE * ROI_SIZE) % NUM_PER_CYCLE != 0) begin : g_bad_geometry
        $error("conv_frame_sequencer: ROI_SIZE^2 not a multiple of pixels per beat");
    end

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    logic [IN_CW-1:0]   r_in_cnt;
    logic [IN_CW-1:0]   r_out_cnt;
    logic [FL_CW-1:0]   r_flush_cnt;
    logic               r_fresh_p1;
    logic               r_err;
    logic [15:0]        r_frame_cnt;
    logic               w_stream;
    logic               w_flush;

    // Core drive decodes straight from state so reset drops it asynchronously.
    assign w_stream     = (r_state == S_STREAM);
    assign w_flush      = (r_state == S_FLUSH);
    assign core_conv_en = w_stream | w_flush;
    assign core_clk_en  = (w_stream & s_if.s_valid) | w_flush;
    assign core_din     = w_stream ? s_if.s_data : '0;
    assign s_if.s_ready = w_stream;
    assign busy         = w_stream | w_flush;
    assign done         = (r_state == S_DONE);
    assign m_valid      = r_fresh_p1 & core_vld;
    assign err          = r_err;
    assign frame_cnt    = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
            r_fresh_p1  <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // core output is new only if the core advanced on the previous edge
            r_fresh_p1 <= core_clk_en;
            if (m_valid && (r_out_cnt != C_BEATS)) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            if (abort && (r_state != S_IDLE)) begin
                r_state    <= S_IDLE;
                r_fresh_p1 <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state     <= S_STREAM;
                            r_in_cnt    <= '0;
                            r_out_cnt   <= '0;
                            r_flush_cnt <= '0;
                            r_err       <= 1'b0;
                        end
                    end
                    S_STREAM: begin
                        if (s_if.s_valid) begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                            if (r_in_cnt == C_LAST_IN) begin
                                r_state <= S_FLUSH;
                            end
                        end
                    end
                    S_FLUSH: begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                        if (r_out_cnt == C_BEATS) begin
                            r_state <= S_DONE;
                        end else if (r_flush_cnt == C_FL_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer with a behavioural 5-stage convolution core model.
module tb_conv_frame_sequencer;
    localparam int PB    = 128;
    localparam int BEATS = 64;
    localparam int FLMAX = 16;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic          abort = 0;
    logic          core_clk_en, core_conv_en, core_vld, m_valid, busy, done, err;
    logic [PB-1:0] core_din;
    logic [15:0]   frame_cnt;

    logic [PB-1:0] cp_d [5];
    logic [4:0]    cp_v;
    logic          vld0 = 0;

    int n_vec = 0, n_mis = 0;
    int exp_fc = 0;
    bit chk_mirror = 0, start_on_done = 0, start_mid = 0;
    bit sv_ready, sv_done;
    int n_flush, n_done;
    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] got_q[$];

    conv_frame_sequencer_if #(.PORT_BITS(PB)) sif ();

    conv_frame_sequencer #(
        .ROI_SIZE(32), .PORT_BITS(PB), .IN_WIDTH(8), .FLUSH_MAX(FLMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_if(sif),
        .core_clk_en(core_clk_en), .core_conv_en(core_conv_en), .core_din(core_din),
        .core_vld(core_vld), .m_valid(m_valid), .busy(busy), .done(done), .err(err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Core: 5 enabled cycles of latency; dropping conv_en empties its pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_v <= '0;
        end else if (!core_conv_en) begin
            cp_v <= '0;
        end else if (core_clk_en) begin
            cp_v    <= {cp_v[3:0], 1'b1};
            cp_d[0] <= core_din;
            for (int i = 1; i < 5; i++) cp_d[i] <= cp_d[i-1];
        end
    end
    assign core_vld = cp_v[4] & ~vld0;

    function automatic logic [PB-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at posedge+1; outputs are sampled at posedge+3.
    task automatic cyc();
        bit pulsed = 0;
        #2;
        if (m_valid) got_q.push_back(cp_d[4]);
        if (core_clk_en && !sif.s_ready && busy) n_flush++;
        if (done) n_done++;
        if (chk_mirror && sif.s_ready) begin
            chk("clk_en_mirror", core_clk_en, sif.s_valid);
            chk("din_pass", core_din, sif.s_data);
        end
        sv_ready = sif.s_ready;
        sv_done  = done;
        if (start_on_done && done) begin
            start  = 1;
            pulsed = 1;
        end
        @(posedge clk);
        #1;
        if (pulsed) start = 0;
    endtask

    task automatic frame(input int mode, input int abort_at, input bit no_start, input bit rst_flush);
        int sent = 0;
        int guard = 0;
        bit exp_err;
        logic [PB-1:0] beat;
        exp_q.delete();
        got_q.delete();
        n_flush = 0;
        n_done  = 0;
        exp_err = vld0;
        if (!no_start) begin
            start = 1;
            cyc();
            start = 0;
        end
        chk("err_after_start", err, 0);
        chk("busy_after_start", busy, 1);
        beat = rnd128();
        while (sent < BEATS && guard < 1000) begin
            if (sent == abort_at) break;
            case (mode)
                1:       sif.s_valid = (guard % 2 == 0);
                2:       sif.s_valid = ($urandom_range(0, 3) != 0);
                default: sif.s_valid = 1;
            endcase
            sif.s_data = sif.s_valid ? beat : rnd128();
            start = (start_mid && guard == 10);
            cyc();
            if (sv_ready && sif.s_valid) begin
                exp_q.push_back(beat);
                sent++;
                beat = rnd128();
            end
            guard++;
        end
        start = 0;
        if (abort_at >= 0) begin
            abort = 1;
            sif.s_valid = 1;
            sif.s_data  = rnd128();
            cyc();
            abort = 0;
            sif.s_valid = 0;
            chk("abort_busy", busy, 0);
            chk("abort_conv_en", core_conv_en, 0);
            for (int i = 0; i < 8; i++) cyc();
            chk("abort_no_done", n_done, 0);
            chk("abort_frame_cnt", frame_cnt, exp_fc);
            return;
        end
        sif.s_valid = 0;
        sif.s_data  = rnd128();
        chk("stream_beats", sent, BEATS);
        if (rst_flush) begin
            cyc();
            cyc();
            chk("in_flush", busy && !sif.s_ready, 1);
            rst_n = 0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_conv_en", core_conv_en, 0);
            chk("rst_clk_en", core_clk_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_err", err, 0);
            exp_fc = 0;
            #2;
            rst_n = 1;
            @(posedge clk);
            #1;
            chk("post_rst_idle", busy, 0);
            chk("post_rst_ready", sif.s_ready, 0);
            return;
        end
        guard = 0;
        sv_done = 0;
        while (!sv_done && guard < 200) begin
            cyc();
            guard++;
        end
        if (!sv_done) chk("done_timeout", 0, 1);
        exp_fc++;
        chk("done_pulses", n_done, 1);
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("err", err, exp_err);
        chk("busy_after_done", busy, 0);
        if (vld0) begin
            chk("timeout_flush_beats", n_flush, FLMAX);
            chk("timeout_no_output", got_q.size(), 0);
        end else begin
            chk("flush_beats_range", (n_flush >= 4 && n_flush <= 8), 1);
            chk("out_beats_min", got_q.size() >= BEATS, 1);
            for (int i = 0; i < got_q.size(); i++) begin
                if (i < BEATS) chk("beat_data", got_q[i], exp_q[i]);
                else           chk("flush_beat_zero", got_q[i], 0);
            end
        end
    endtask

    initial begin
        sif.s_valid = 0;
        sif.s_data  = '0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_conv_en", core_conv_en, 0);
        chk("reset_clk_en", core_clk_en, 0);
        chk("reset_ready", sif.s_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_din", core_din, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;

        frame(0, -1, 0, 0);
        chk_mirror = 1;
        frame(1, -1, 0, 0);
        frame(2, -1, 0, 0);
        chk_mirror = 0;

        frame(0, 20, 0, 0);
        frame(2, -1, 0, 0);

        vld0 = 1;
        frame(0, -1, 0, 0);
        vld0 = 0;
        frame(0, -1, 0, 0);

        start_mid     = 1;
        start_on_done = 1;
        frame(2, -1, 0, 0);
        start_mid     = 0;
        start_on_done = 0;
        chk("start_in_done_ignored", busy, 0);
        start = 1;
        cyc();
        start = 0;
        frame(0, -1, 1, 0);

        frame(0, -1, 0, 1);
        frame(2, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
